// File: rtl/riscv_pkg.sv
// Shared core types and constants used by the writeback path: the packed writeback
// request and the default depth/starvation settings of the writeback arbiter.
package riscv_pkg;

  localparam int XLEN            = 32;
  localparam int WB_FIFO_DEPTH   = 2;
  localparam int WB_STARVE_LIMIT = 4;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests. Pointers carry one extra wrap bit so
// that full and empty can be told apart when the index bits are equal.
module wb_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);

  localparam int AW = $clog2(DEPTH);

  wb_req_t    mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: merges in-order pipeline writebacks with buffered
// long-latency results and tracks registers whose long-latency result is outstanding.
module wb_arbiter
  import riscv_pkg::*;
#(
  parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pipe_wr_en,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_data,
  output logic            pipe_stall,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      q_rs1,
  input  logic [4:0]      q_rs2,
  input  logic [4:0]      q_rd,
  output logic            q_rs1_busy,
  output logic            q_rs2_busy,
  output logic            q_rd_busy,
  output logic            rf_wr_en,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wr_data
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  wb_req_t       fifo_head;
  wb_req_t       lu_req;
  logic          pipe_req;
  logic          starve;
  logic          fifo_grant;
  logic          pipe_grant;
  logic [CW-1:0] starve_cnt;
  logic [31:0]   pending;
  logic [31:0]   set_mask;
  logic [31:0]   clr_mask;

  assign lu_req    = '{rd: lu_rd, data: lu_data};
  assign lu_ready  = !rst && !fifo_full;
  assign fifo_push = lu_valid && lu_ready;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (lu_req),
    .pop       (fifo_grant),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // A starved FIFO head preempts the pipeline; otherwise the pipeline has priority.
  assign pipe_req   = pipe_wr_en && (pipe_rd != 5'd0);
  assign starve     = (starve_cnt == CW'(STARVE_LIMIT));
  assign fifo_grant = !rst && !fifo_empty && (starve || !pipe_req);
  assign pipe_grant = !rst && pipe_req && !(starve && !fifo_empty);
  assign pipe_stall = !rst && starve && !fifo_empty;

  always_comb begin
    rf_wr_en   = 1'b0;
    rf_rd      = 5'd0;
    rf_wr_data = '0;
    if (fifo_grant) begin
      rf_wr_en   = (fifo_head.rd != 5'd0);
      rf_rd      = fifo_head.rd;
      rf_wr_data = fifo_head.data;
    end else if (pipe_grant) begin
      rf_wr_en   = 1'b1;
      rf_rd      = pipe_rd;
      rf_wr_data = pipe_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || fifo_empty || fifo_grant) begin
      starve_cnt <= '0;
    end else if (pipe_grant && !starve) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Set is OR-ed in after the clear so a same-cycle issue to a retiring rd stays pending.
  assign set_mask = (issue_valid && issue_rd != 5'd0) ? (32'd1 << issue_rd) : 32'd0;
  assign clr_mask = fifo_grant ? (32'd1 << fifo_head.rd) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && issue_valid && issue_rd != 5'd0) begin
      assert (!pending[issue_rd] || clr_mask[issue_rd]);
    end
  end

  assign q_rs1_busy = pending[q_rs1];
  assign q_rs2_busy = pending[q_rs2];
  assign q_rd_busy  = pending[q_rd];

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: table of pipeline-only writebacks plus directed multi-cycle
// sequences, with FIFO results checked in order against a queue of pushed entries.
module tb_wb_arbiter;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        pipe_wr_en;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  q_rs1, q_rs2, q_rd;
  logic        q_rs1_busy, q_rs2_busy, q_rd_busy;
  logic        rf_wr_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  wb_req_t exp_q[$];

  typedef struct {
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        exp_en;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_wr_en(pipe_wr_en), .pipe_rd(pipe_rd), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
    .q_rs1_busy(q_rs1_busy), .q_rs2_busy(q_rs2_busy), .q_rd_busy(q_rd_busy),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_wr_data(rf_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
    pipe_wr_en = v; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd);
    issue_valid = v; issue_rd = rd;
  endtask

  // acc states whether this cycle's lu_valid is expected to be taken into the FIFO.
  task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic acc);
    lu_valid = v; lu_rd = rd; lu_data = d;
    if (v && acc) exp_q.push_back('{rd: rd, data: d});
  endtask

  task automatic chk_pop(input string nm);
    wb_req_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got rf_rd=%0d", nm, rf_rd);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_en"}, rf_wr_en, (e.rd != 5'd0));
      chk({nm, "_rd"}, rf_rd, e.rd);
      chk({nm, "_data"}, rf_wr_data, e.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 5'd1,  32'h1111_1111, 1'b1, 5'd1,  32'h1111_1111};
    vecs[1] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 5'd0,  32'h1234_5678, 1'b0, 5'd0,  32'h0};
    vecs[3] = '{1'b0, 5'd7,  32'h0000_ABCD, 1'b0, 5'd0,  32'h0};
    vecs[4] = '{1'b1, 5'd16, 32'h8000_0000, 1'b1, 5'd16, 32'h8000_0000};

    rst = 1'b1;
    pipe(1'b1, 5'd7, 32'h77);
    lu(1'b1, 5'd4, 32'h1, 1'b0);
    issue(1'b0, 5'd0);
    q_rs1 = 5'd4; q_rs2 = 5'd5; q_rd = 5'd31;

    // Reset: everything forced low even with requests present.
    @(negedge clk); #1;
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_lu_ready", lu_ready, 0);
    chk("rst_stall", pipe_stall, 0);
    step(); #1;
    chk("rst_wr_en2", rf_wr_en, 0);
    chk("rst_lu_ready2", lu_ready, 0);

    step();
    rst = 1'b0;
    pipe(1'b0, 5'd0, 32'h0);
    lu(1'b0, 5'd0, 32'h0, 1'b0);
    #1;
    chk("post_rst_lu_ready", lu_ready, 1);
    chk("post_rst_wr_en", rf_wr_en, 0);
    chk("post_rst_busy_rs1", q_rs1_busy, 0);
    chk("post_rst_busy_rs2", q_rs2_busy, 0);
    chk("post_rst_busy_rd", q_rd_busy, 0);

    // Pipeline-only writebacks with the FIFO empty.
    for (int i = 0; i < 5; i++) begin
      step();
      pipe(vecs[i].pwe, vecs[i].prd, vecs[i].pdata);
      #1;
      chk($sformatf("vec%0d_en", i), rf_wr_en, vecs[i].exp_en);
      chk($sformatf("vec%0d_rd", i), rf_rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d_data", i), rf_wr_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_stall", i), pipe_stall, 0);
    end
    step(); pipe(1'b0, 5'd0, 32'h0);

    // Long-latency result x5 with busy tracking.
    step(); issue(1'b1, 5'd5); q_rs1 = 5'd5; #1;
    chk("a_busy_t0", q_rs1_busy, 0);
    step(); issue(1'b0, 5'd0); #1;
    chk("a_busy_t1", q_rs1_busy, 1);
    step(); #1;
    chk("a_busy_t2", q_rs1_busy, 1);
    step(); lu(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1); #1;
    chk("a_busy_t3", q_rs1_busy, 1);
    chk("a_no_bypass", rf_wr_en, 0);
    step(); lu(1'b0, 5'd0, 32'h0, 1'b0); #1;
    chk_pop("a_pop");
    chk("a_busy_t4", q_rs1_busy, 1);
    step(); #1;
    chk("a_busy_t5", q_rs1_busy, 0);
    chk("a_idle", rf_wr_en, 0);

    // Starvation: pipe keeps writing x7 while x9 waits in the FIFO.
    step(); issue(1'b1, 5'd9); lu(1'b1, 5'd9, 32'h99, 1'b1); pipe(1'b1, 5'd7, 32'h70); #1;
    chk("b_c0_rd", rf_rd, 7);
    for (int i = 1; i <= 4; i++) begin
      step(); issue(1'b0, 5'd0); lu(1'b0, 5'd0, 32'h0, 1'b0); pipe(1'b1, 5'd7, 32'h70 + i); #1;
      chk($sformatf("b_c%0d_rd", i), rf_rd, 7);
      chk($sformatf("b_c%0d_data", i), rf_wr_data, 32'h70 + i);
      chk($sformatf("b_c%0d_stall", i), pipe_stall, 0);
    end
    step(); pipe(1'b1, 5'd7, 32'h75); #1;
    chk("b_starve_stall", pipe_stall, 1);
    chk_pop("b_starve_pop");
    step(); #1;
    chk("b_retry_stall", pipe_stall, 0);
    chk("b_retry_rd", rf_rd, 7);
    chk("b_retry_data", rf_wr_data, 32'h75);

    // Fill the FIFO behind a busy pipe; a held third result waits for the first pop.
    step(); pipe(1'b1, 5'd7, 32'hC0); lu(1'b1, 5'd10, 32'hA0, 1'b1); #1;
    chk("c_ready0", lu_ready, 1);
    step(); lu(1'b1, 5'd11, 32'hA1, 1'b1); #1;
    chk("c_ready1", lu_ready, 1);
    for (int i = 2; i <= 4; i++) begin
      step(); lu(1'b1, 5'd12, 32'hA2, 1'b0); #1;
      chk($sformatf("c_full%0d_ready", i), lu_ready, 0);
      chk($sformatf("c_full%0d_rd", i), rf_rd, 7);
    end
    step(); #1;
    chk("c_pop_ready", lu_ready, 0);
    chk("c_pop_stall", pipe_stall, 1);
    chk_pop("c_pop0");
    step(); lu(1'b1, 5'd12, 32'hA2, 1'b1); #1;
    chk("c_accept_ready", lu_ready, 1);
    chk("c_accept_rd", rf_rd, 7);
    step(); lu(1'b0, 5'd0, 32'h0, 1'b0); pipe(1'b0, 5'd0, 32'h0); #1;
    chk_pop("c_pop1");
    step(); #1;
    chk_pop("c_pop2");
    step(); #1;
    chk("c_drained", rf_wr_en, 0);

    // Pop of x3 and a new issue to x3 in the same cycle: x3 stays pending.
    step(); issue(1'b1, 5'd3); q_rd = 5'd3; #1;
    chk("d_busy0", q_rd_busy, 0);
    step(); issue(1'b0, 5'd0); lu(1'b1, 5'd3, 32'h33, 1'b1); #1;
    chk("d_busy1", q_rd_busy, 1);
    step(); lu(1'b0, 5'd0, 32'h0, 1'b0); issue(1'b1, 5'd3); #1;
    chk_pop("d_pop");
    chk("d_busy2", q_rd_busy, 1);
    step(); issue(1'b0, 5'd0); lu(1'b1, 5'd3, 32'h34, 1'b1); #1;
    chk("d_set_wins", q_rd_busy, 1);
    step(); lu(1'b0, 5'd0, 32'h0, 1'b0); #1;
    chk_pop("d_pop2");
    step(); #1;
    chk("d_cleared", q_rd_busy, 0);

    // Result to x0: popped without a write, mask left alone.
    step(); issue(1'b1, 5'd6); q_rs2 = 5'd6; q_rd = 5'd0; #1;
    step(); issue(1'b0, 5'd0); lu(1'b1, 5'd0, 32'hFF, 1'b1); #1;
    chk("e_busy6", q_rs2_busy, 1);
    step(); lu(1'b0, 5'd0, 32'h0, 1'b0); #1;
    chk_pop("e_pop_x0");
    step(); #1;
    chk("e_busy6_kept", q_rs2_busy, 1);
    chk("e_x0_busy", q_rd_busy, 0);
    chk("e_empty", rf_wr_en, 0);
    lu(1'b1, 5'd6, 32'h66, 1'b1);
    step(); lu(1'b0, 5'd0, 32'h0, 1'b0); #1;
    chk_pop("e_pop6");
    step(); #1;
    chk("e_busy6_clear", q_rs2_busy, 0);
    chk("e_scoreboard_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Sits between the writeback sources and the register file's single write port.
- Merges in-order pipeline writebacks with out-of-order results from a long-latency unit (mul/div), which are buffered in a small FIFO.
- Keeps a 32-entry pending-register scoreboard so the hazard logic can stall readers and writers of registers whose long-latency result has not yet been written.

Parameters:
- XLEN, 32 (from riscv_pkg): data width.
- FIFO_DEPTH, 2: long-latency result buffer entries; power of two, at least 2.
- STARVE_LIMIT, 4: consecutive cycles a FIFO head may lose arbitration before the pipeline is stalled.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pipe_wr_en  in  1  pipeline WB write request
- pipe_rd  in  5  pipeline WB destination
- pipe_data  in  XLEN  pipeline WB data
- pipe_stall  out  1  WB must hold its instruction and retry next cycle
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept
- lu_rd  in  5  long-latency destination
- lu_data  in  XLEN  long-latency result
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  5  its destination
- q_rs1  in  5  hazard query
- q_rs2  in  5  hazard query
- q_rd  in  5  hazard query
- q_rs1_busy  out  1  q_rs1 is pending
- q_rs2_busy  out  1  q_rs2 is pending
- q_rd_busy  out  1  q_rd is pending
- rf_wr_en  out  1  register file write enable
- rf_rd  out  5  register file write address
- rf_wr_data  out  XLEN  register file write data

Behaviour:
- Reset (synchronous, active-high): FIFO empty, pending mask cleared, starve counter 0. While rst is high, rf_wr_en, lu_ready and pipe_stall are forced to 0.
- lu_ready = FIFO not full.
- Push: when lu_valid && lu_ready. Results never bypass the FIFO, so minimum latency from lu_valid to rf_wr_en is 1 cycle.
- pipe_req = pipe_wr_en && pipe_rd != 0.
- Grant:
  - If starve (counter == STARVE_LIMIT) and the FIFO is not empty, the FIFO head wins and pipe_stall = 1.
  - Else if pipe_req, the pipeline wins.
  - Else the FIFO head wins if the FIFO is not empty.
- Pop: occurs whenever the FIFO head is granted.
- Starve counter:
  - Increments when the FIFO is not empty and pipe_req wins.
  - Resets to 0 on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Outputs are combinational from the grant:
  - rf_wr_en = 1 when the granted source writes a register with rd != 0.
  - rf_rd and rf_wr_data come from the granted source.
  - When no source is granted, rf_wr_en = 0 and rf_rd / rf_wr_data are 0.
- A FIFO entry with rd = 0 is popped with rf_wr_en = 0 and does not change the scoreboard.
- Scoreboard:
  - issue_valid && issue_rd != 0 sets pending[issue_rd] at the next edge.
  - A pop of rd clears pending[rd].
  - If set and clear target the same rd in the same cycle, set wins.
  - Issuing to an already-pending rd is illegal. Assert in simulation; the hazard unit prevents it via q_rd_busy.
- Query outputs are combinational from the registered mask only; the same-cycle clear is not forwarded. x0 always reads not-busy.
- Simultaneous push and pop on a full FIFO: the push is refused because lu_ready reflects the full state.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished with an extra pointer bit.

Decomposition:
- riscv_pkg additions: typedef wb_req_t (packed struct: rd[4:0], data[XLEN-1:0]); constants WB_FIFO_DEPTH and WB_STARVE_LIMIT.
- One sub-module, wb_fifo: synchronous FIFO of wb_req_t, parameterised depth, with push/pop/full/empty/head ports.
- Arbitration, starve counter and scoreboard stay in wb_arbiter.

Test Plan:
- Reset with lu_valid=1 held → no push, rf_wr_en=0, lu_ready=0. Cycle after reset: lu_ready=1, mask=0.
- issue x5 at t0; lu result x5=0xDEADBEEF at t3, pipe idle → q_rs1=5 busy over t1–t4. rf_wr_en=1, rf_rd=5, data=0xDEADBEEF at t4. Busy clears at t5.
- Pipe writes x7 every cycle while FIFO holds x9 → pipe wins 4 cycles, then pipe_stall=1 and x9 written. Next cycle the pipe retries x7 and wins.
- Push 2 results with pipe busy → lu_ready=0 while full. Third lu_valid held is accepted the cycle after the first pop.
- Pop of x3 and issue to x3 in the same cycle → pending[3] remains 1.
- lu result to x0 → popped, rf_wr_en=0, mask unchanged. Query q_rd=0 → busy=0.
